// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, WIDTH clocks per operation, result published only on entry to DONE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-2:0] res_reg;
  logic             br_reg;
  logic [CW-1:0]    cnt_reg;

  logic             d_bit, br_next, last_bit;
  logic [WIDTH-1:0] res_next;

  assign d_bit    = a_reg[0] ^ b_reg[0] ^ br_reg;
  assign br_next  = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br_reg);
  // Bit 0 of the shifted word would fall off, so only WIDTH-1 partial bits are stored.
  assign res_next = {d_bit, res_reg};
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      br_reg     <= 1'b0;
      cnt_reg    <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            br_reg  <= 1'b0;
            cnt_reg <= '0;
          end
        end
        SHIFT: begin
          res_reg <= res_next[WIDTH-1:1];
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          br_reg  <= br_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_bit) begin
            diff       <= res_next;
            borrow_out <= br_next;
            zero       <= (res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vector table,
// hand-written corner sequences and a randomized regression against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic         ready, busy, done, borrow_out, zero;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] hold_d;
  logic         hold_b, hold_z;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done),
    .diff(diff), .borrow_out(borrow_out), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ed;
    logic         eb;
    logic         ez;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One operation starting from an IDLE cycle (called #1 after a rising edge).
  // rst_at >= 0 aborts the operation with reset in SHIFT cycle rst_at+1.
  // pulse_at >= 0 pulses a competing start (a=FF,b=00) in SHIFT cycle pulse_at+1.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic [W-1:0] ed, input logic eb, input logic ez,
                        input int rst_at, input int pulse_at, input bit noise);
    check("ready_before_start", ready, 1);
    a = op_a; b = op_b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    for (int k = 0; k < W; k++) begin
      check("busy_in_shift", busy, 1);
      check("done_early", done, 0);
      check("diff_held_in_shift", diff, hold_d);
      check("borrow_held_in_shift", borrow_out, hold_b);
      if (k == rst_at) begin
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        check("rst_zero", zero, 0);
        hold_d = '0; hold_b = 1'b0; hold_z = 1'b0;
        @(posedge clk); #1;
        check("no_done_after_abort", done, 0);
        check("idle_after_abort", ready, 1);
        return;
      end
      if (k == pulse_at) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end else if (noise) begin
        start = 1'($urandom); a = W'($urandom); b = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("done_latency", done, 1);
    check("busy_in_done", busy, 0);
    check("ready_in_done", ready, 0);
    check("diff", diff, ed);
    check("borrow_out", borrow_out, eb);
    check("zero", zero, ez);
    hold_d = ed; hold_b = eb; hold_z = ez;
    start = noise ? 1'($urandom) : 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("ready_after_done", ready, 1);
    check("done_single_pulse", done, 0);
    check("diff_held_idle", diff, hold_d);
    check("zero_held_idle", zero, hold_z);
  endtask

  initial begin
    int ndone;
    logic [W-1:0] ra, rb, md;
    logic mb;
    int rst_at;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h77, 8'h77, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};

    // Reset with start held high: must come up idle and ignore start.
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_borrow", borrow_out, 0);
    check("reset_zero", zero, 0);
    rst = 1'b0; start = 1'b0;
    hold_d = '0; hold_b = 1'b0; hold_z = 1'b0;
    @(posedge clk); #1;
    check("idle_stays_idle", busy, 0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, vecs[i].ez, -1, -1, 1'b0);
      $display("vec %0d: %02h - %02h -> diff=%02h borrow=%0d zero=%0d",
               i, vecs[i].va, vecs[i].vb, diff, borrow_out, zero);
    end

    // Competing start during SHIFT cycle 3 must be ignored.
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, -1, 2, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("ignored_start_no_op", busy, 0);
    end
    $display("ignored-start case: diff=%02h", diff);

    // Reset in SHIFT cycle 4, then a clean operation.
    run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 3, -1, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, -1, -1, 1'b0);
    $display("after abort: diff=%02h borrow=%0d", diff, borrow_out);

    // Continuous start: back-to-back operations spaced WIDTH+2 cycles apart.
    ndone = 0;
    start = 1'b1; a = 8'h30; b = 8'h10;
    for (int c = 1; c <= 2 * W + 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin a = 8'h10; b = 8'h30; end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("cont_first_time", c, W + 1);
          check("cont_first_diff", diff, 8'h20);
        end else begin
          check("cont_second_time", c, 2 * W + 3);
          check("cont_second_diff", diff, 8'hE0);
          check("cont_second_borrow", borrow_out, 1);
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("cont_done_count", ndone, 2);
    @(posedge clk); #1;
    check("cont_ready_after", ready, 1);
    hold_d = diff; hold_b = borrow_out; hold_z = zero;
    $display("continuous start: %0d operations", ndone);

    // Randomized regression against the arithmetic model.
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        check("rand_idle_ready", ready, 1);
        check("rand_idle_done", done, 0);
      end
      ra = W'($urandom);
      rb = W'($urandom);
      md = W'((int'(ra) - int'(rb) + 256) % 256);
      mb = (int'(ra) < int'(rb));
      rst_at = ($urandom_range(0, 31) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run_op(ra, rb, md, mb, (md == 0), rst_at, -1, 1'b1);
      if (i % 500 == 0)
        $display("rand %0d: %02h - %02h rst_at=%0d diff=%02h borrow=%0d",
                 i, ra, rb, rst_at, diff, borrow_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
